// File: rtl/intersection_pkg.sv
// Shared types for the two-road intersection controller: phase encoding and lamp vector.
package intersection_pkg;

    typedef enum logic [2:0] {
        ALL_RED_B = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_A = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6
    } phase_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    localparam lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
    localparam lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
    localparam lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Loadable down-counter that saturates at zero; done is registered and high while the count is zero.
module phase_timer #(
    parameter int unsigned      CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_q;
        if (load) begin
            cnt_nxt = load_val;
        end else if (cnt_q != '0) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
            done  <= (RST_VAL == '0);
        end else begin
            cnt_q <= cnt_nxt;
            done  <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection phase sequencer with all-red clearance and NS green hold.
// Optional pedestrian walk phase is built when INTERSECTION_PED_EN is defined.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int unsigned NS_GREEN_T = 8,
    parameter int unsigned EW_GREEN_T = 4,
    parameter int unsigned YELLOW_T   = 2,
    parameter int unsigned ALLRED_T   = 1,
    parameter int unsigned PED_T      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int unsigned MAX_T = max2(max2(max2(NS_GREEN_T, EW_GREEN_T), max2(YELLOW_T, ALLRED_T)), PED_T);
    localparam int unsigned CNT_W = $clog2(MAX_T) + 1;

    phase_t           phase_q;
    phase_t           phase_nxt;
    lamp_t            ns_q, ew_q, ns_nxt, ew_nxt;
    logic             walk_q, walk_nxt;
    logic             tmr_load;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic             ped_pending;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(ALLRED_T - 1))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next phase, timer reload and lamp decode of the phase being entered.
    always_comb begin
        phase_nxt = phase_q;
        ns_nxt    = LAMP_RED;
        ew_nxt    = LAMP_RED;
        walk_nxt  = 1'b0;
        tmr_val   = CNT_W'(ALLRED_T - 1);

        case (phase_q)
            NS_GREEN:  if (tmr_done && (ew_req || ped_pending)) phase_nxt = NS_YELLOW;
            NS_YELLOW: if (tmr_done) phase_nxt = ALL_RED_A;
            ALL_RED_A: if (tmr_done) phase_nxt = EW_GREEN;
            EW_GREEN:  if (tmr_done) phase_nxt = EW_YELLOW;
            EW_YELLOW: if (tmr_done) phase_nxt = ALL_RED_B;
            ALL_RED_B: if (tmr_done) phase_nxt = ped_pending ? PED_WALK : NS_GREEN;
`ifdef INTERSECTION_PED_EN
            PED_WALK:  if (tmr_done) phase_nxt = NS_GREEN;
`endif
            default:   phase_nxt = ALL_RED_B;
        endcase

        // The NS hold leaves the phase unchanged, so the timer stays saturated.
        tmr_load = (phase_nxt != phase_q);

        case (phase_nxt)
            NS_GREEN: begin
                ns_nxt  = LAMP_GREEN;
                tmr_val = CNT_W'(NS_GREEN_T - 1);
            end
            NS_YELLOW: begin
                ns_nxt  = LAMP_YELLOW;
                tmr_val = CNT_W'(YELLOW_T - 1);
            end
            EW_GREEN: begin
                ew_nxt  = LAMP_GREEN;
                tmr_val = CNT_W'(EW_GREEN_T - 1);
            end
            EW_YELLOW: begin
                ew_nxt  = LAMP_YELLOW;
                tmr_val = CNT_W'(YELLOW_T - 1);
            end
`ifdef INTERSECTION_PED_EN
            PED_WALK: begin
                walk_nxt = 1'b1;
                tmr_val  = CNT_W'(PED_T - 1);
            end
`endif
            default: tmr_val = CNT_W'(ALLRED_T - 1);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= ALL_RED_B;
            ns_q    <= LAMP_RED;
            ew_q    <= LAMP_RED;
            walk_q  <= 1'b0;
        end else begin
            phase_q <= phase_nxt;
            ns_q    <= ns_nxt;
            ew_q    <= ew_nxt;
            walk_q  <= walk_nxt;
        end
    end

`ifdef INTERSECTION_PED_EN
    // Entering PED_WALK clears the request; a ped_req on that edge is absorbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending <= 1'b0;
        end else if (phase_nxt == PED_WALK && phase_q != PED_WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_req && phase_q != PED_WALK) begin
            ped_pending <= 1'b1;
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_pending    = 1'b0;
`endif

    assign ns_red    = ns_q.red;
    assign ns_yellow = ns_q.yellow;
    assign ns_green  = ns_q.green;
    assign ew_red    = ew_q.red;
    assign ew_yellow = ew_q.yellow;
    assign ew_green  = ew_q.green;
    assign walk      = walk_q;
    assign phase     = phase_q;

endmodule

// File: doc/intersection_ctrl.md
Name: intersection_ctrl

Overview:
- Two-road intersection controller that sequences a north-south (NS) light head and an east-west (EW) light head through mutually exclusive phases.
- Inserts all-red clearance between conflicting greens.
- Holds NS (main road) green until a side-road car or a pedestrian request arrives.
- Sits above the per-head lamp drivers in the traffic_light design area and is the single source of lamp timing for the intersection.

Parameters:
- NS_GREEN_T, 8: minimum NS green duration in cycles (>=1).
- EW_GREEN_T, 4: fixed EW green duration in cycles (>=1).
- YELLOW_T, 2: yellow duration for either road in cycles (>=1).
- ALLRED_T, 1: all-red clearance duration in cycles (>=1).
- PED_T, 3: pedestrian walk duration in cycles (>=1; used only with the optional feature).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ew_req  in  1  level; EW vehicle sensor.
- ped_req  in  1  pedestrian button; a one-cycle pulse or longer level.
- ns_red  out  1  NS red lamp.
- ns_yellow  out  1  NS yellow lamp.
- ns_green  out  1  NS green lamp.
- ew_red  out  1  EW red lamp.
- ew_yellow  out  1  EW yellow lamp.
- ew_green  out  1  EW green lamp.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current phase encoding, for debug and bench.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state:
  - Phase = ALL_RED_B; timer loaded with ALLRED_T-1.
  - ns_red = ew_red = 1; all other lamps and walk = 0; ped_pending = 0.
- Outputs are Moore-decoded from the phase register, so they change on the clock edge that changes phase.
- Every phase lasts exactly T cycles before it can exit:
  - Timer loads T-1 on phase entry and decrements each cycle.
  - Exit is evaluated when the timer reads 0; the next phase is entered on the following edge.
- Phase sequence and lamps:
  - NS_GREEN: ns_green, ew_red. Timer from NS_GREEN_T. At timer 0, go to NS_YELLOW if ew_req or ped_pending; otherwise hold with the timer saturated at 0. No wrap.
  - NS_YELLOW: ns_yellow, ew_red. Lasts YELLOW_T, then ALL_RED_A.
  - ALL_RED_A: both red. Lasts ALLRED_T, then EW_GREEN.
  - EW_GREEN: ew_green, ns_red. Lasts EW_GREEN_T, then EW_YELLOW, regardless of ew_req.
  - EW_YELLOW: ew_yellow, ns_red. Lasts YELLOW_T, then ALL_RED_B.
  - ALL_RED_B: both red. Lasts ALLRED_T, then PED_WALK if ped_pending (feature on), else NS_GREEN.
  - PED_WALK: both red, walk=1. Lasts PED_T, then NS_GREEN.
- Safety invariants, which must hold every cycle including during reset:
  - ns_green and ew_green are never both 1.
  - Exactly one lamp is lit per head.
  - walk=1 implies both reds are 1.
- Timer width: CNT_W = $clog2(max of all T)+1, unsigned. All loads are zero-extended.
- Reset mid-phase: returns immediately (asynchronously) to the reset state. ped_pending is lost.
- ew_req has no effect outside the NS_GREEN exit decision.

Optional Feature:
- Macro: INTERSECTION_PED_EN.
- Defined:
  - ped_req sets ped_pending on any cycle where it is 1.
  - ped_pending clears on the edge entering PED_WALK. A ped_req on that same edge is absorbed: clear wins.
  - ped_req during PED_WALK is ignored.
  - A pending request also ends the NS_GREEN hold.
- Undefined:
  - ped_req is ignored; walk is tied to 0.
  - The PED_WALK phase and ped_pending register are not built.
  - The ports remain present so the port list is identical.

Decomposition:
- Package intersection_pkg:
  - phase_t enum, 3 bits: ALL_RED_B=0, NS_GREEN=1, NS_YELLOW=2, ALL_RED_A=3, EW_GREEN=4, EW_YELLOW=5, PED_WALK=6.
  - Lamp-vector typedef {red, yellow, green}.
- One sub-module, phase_timer:
  - Loadable down-counter with a saturating-zero `done` flag.
  - Parameterised by CNT_W.
  - Same clk and asynchronous rst.

Test Plan (NS_GREEN_T=6, EW_GREEN_T=4, YELLOW_T=2, ALLRED_T=1, PED_T=3):
- Reset hold 2 cycles, ew_req=0:
  - During reset, both reds are 1.
  - One ALL_RED_B cycle after release, then NS_GREEN.
  - NS_GREEN holds for at least 50 cycles with no yellow.
- ew_req=1 from reset release: phase durations are NS_GREEN 6, NS_YELLOW 2, ALL_RED_A 1, EW_GREEN 4, EW_YELLOW 2, ALL_RED_B 1, then NS_GREEN. Checked by cycle counts.
- ew_req pulsed while the NS_GREEN timer is at 3, deasserted before timer 0: remains in NS_GREEN (hold). ew_req is a level, not latched.
- (INTERSECTION_PED_EN) 1-cycle ped_req during NS_GREEN hold:
  - Walks full cycle to ALL_RED_B.
  - Then PED_WALK for 3 cycles with walk=1 and both reds=1.
  - Then NS_GREEN holds again.
- (INTERSECTION_PED_EN) ped_req held high across PED_WALK entry: exactly one PED_WALK is served; no second walk next cycle unless ped_req recurs after entry.
- Async rst asserted mid-EW_GREEN, between clock edges: lamps go to both red immediately, before the next edge. The safety invariants are asserted throughout every test.
